// File: rtl/prog_freq_div.sv
// Programmable multi-channel clock divider with glitch-free divisor updates at period boundaries.
// Optional per-channel period-start tick outputs are enabled by defining PROG_FREQ_DIV_TICK_EN.
module prog_freq_div #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [3:0]        load_ch,
  input  logic [DIV_W-1:0]  load_div,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [4:0]       CH_LIMIT = 5'(NUM_CH);

  // Divisors of 0 and 1 are clamped to 2 so every channel always toggles.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < TWO) ? TWO : d;
  endfunction

  logic load_ok;
  assign load_ok = load && ({1'b0, load_ch} < CH_LIMIT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pdiv_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] e_cur;
    logic [DIV_W-1:0] e_nxt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             pend_q;
    logic             out_q;
    logic             wrap;
    logic             sel;

    assign sel     = load_ok && (load_ch == 4'(i));
    assign e_cur   = eff_div(div_q);
    assign wrap    = en && (cnt_q == e_cur - ONE);
    // At a wrap with a pending divisor the new period starts at cnt = 0 under the new divisor.
    assign e_nxt   = (wrap && pend_q) ? eff_div(pdiv_q) : e_cur;
    assign cnt_nxt = wrap ? '0 : cnt_q + ONE;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        div_q  <= RST_DIV;
        pdiv_q <= '0;
        pend_q <= 1'b0;
        out_q  <= 1'b0;
      end else begin
        if (en) begin
          cnt_q <= cnt_nxt;
          out_q <= (cnt_nxt >= (e_nxt >> 1));
        end
        if (wrap && pend_q) begin
          div_q  <= pdiv_q;
          pend_q <= 1'b0;
        end
        // A load on the wrap edge stays pending for the following wrap.
        if (sel) begin
          pdiv_q <= load_div;
          pend_q <= 1'b1;
        end
      end
    end

    assign out[i]  = out_q;
    assign pend[i] = pend_q;

`ifdef PROG_FREQ_DIV_TICK_EN
    logic tick_q;
    always_ff @(posedge clk) begin
      if (rst) tick_q <= 1'b0;
      else     tick_q <= wrap;
    end
    assign tick[i] = tick_q;
`else
    assign tick[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_prog_freq_div.sv
// Directed bench for prog_freq_div (NUM_CH=2, DIV_W=8, DEFAULT_DIV=4).
// Tick expectations collapse to 0 when PROG_FREQ_DIV_TICK_EN is not defined.
module tb_prog_freq_div;

`ifdef PROG_FREQ_DIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_ch = 4'd0;
  logic [7:0] load_div = 8'd0;
  logic [1:0] out;
  logic [1:0] tick;
  logic [1:0] pend;

  int checks = 0;
  int errors = 0;

  prog_freq_div #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_ch(load_ch),
    .load_div(load_div), .out(out), .tick(tick), .pend(pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] ch;
    logic [7:0] div;
    logic [1:0] out;
    logic [1:0] tick;
    logic [1:0] pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic l,
                              input logic [3:0] c, input logic [7:0] d,
                              input logic [1:0] o, input logic [1:0] t, input logic [1:0] p);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.ch = c; v.div = d;
    v.out = o; v.tick = t; v.pend = p;
    vecs.push_back(v);
  endfunction

  // One clock edge: drive on the falling edge, check just after the rising edge.
  task automatic apply(input vec_t v, input string name);
    logic [1:0] exp_tick;
    @(negedge clk);
    rst = v.rst; en = v.en; load = v.load; load_ch = v.ch; load_div = v.div;
    @(posedge clk);
    #1;
    exp_tick = TICK_ON ? v.tick : 2'b00;
    checks++;
    if (out !== v.out) begin
      errors++;
      $display("FAIL %s out: got %b want %b", name, out, v.out);
    end
    checks++;
    if (tick !== exp_tick) begin
      errors++;
      $display("FAIL %s tick: got %b want %b", name, tick, exp_tick);
    end
    checks++;
    if (pend !== v.pend) begin
      errors++;
      $display("FAIL %s pend: got %b want %b", name, pend, v.pend);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [3:0] c, input logic [7:0] d,
                      input logic [1:0] o, input logic [1:0] t, input logic [1:0] p,
                      input string name);
    vec_t v;
    v.rst = r; v.en = e; v.load = l; v.ch = c; v.div = d;
    v.out = o; v.tick = t; v.pend = p;
    apply(v, name);
  endtask

  initial begin
    // Bit order in out/tick/pend is {ch1, ch0}.
    // reset held 3 cycles
    add(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    // default divide-by-4 on both channels
    add(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00);
    // ch1 <- 5 loaded at cnt=1, applied at the next wrap
    add(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(0, 1, 1, 1, 5, 2'b11, 2'b00, 2'b10);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b10);
    add(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b10, 2'b01, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00);
    add(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b10, 2'b01, 2'b00);
    // ch0 <- 0 then 1: both clamp to period 2
    add(0, 1, 1, 0, 0, 2'b10, 2'b00, 2'b01);
    add(0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b01);
    add(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b01);
    add(0, 1, 0, 0, 0, 2'b10, 2'b01, 2'b00);
    add(0, 1, 1, 0, 1, 2'b11, 2'b00, 2'b01);
    add(0, 1, 0, 0, 0, 2'b10, 2'b01, 2'b00);
    add(0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00);
    // out-of-range channel load ignored
    add(0, 1, 1, 3, 9, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b10, 2'b01, 2'b00);
    add(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00);
    add(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // pending load discarded by reset; reset also beats a simultaneous load
    step(0, 1, 1, 0, 7, 2'b01, 2'b00, 2'b01, "rstpend_load");
    step(1, 1, 1, 1, 9, 2'b00, 2'b00, 2'b00, "rstpend_rst");
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, "rstpend_c1");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, "rstpend_c2");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, "rstpend_c3");
    step(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00, "rstpend_wrap");
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, "rstpend_c1b");

    // en low for 3 cycles mid-period, then the remaining 2 cycles complete it
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, "freeze_pre");
    step(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, "freeze_h1");
    step(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, "freeze_h2");
    step(0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, "freeze_h3");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, "freeze_res");
    step(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00, "freeze_wrap");
    step(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, "freeze_tick0");
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, "freeze_c1");

    // loads while disabled, overwrite, then a load coinciding with the wrap
    step(0, 0, 1, 1, 3, 2'b00, 2'b00, 2'b10, "ovr_load3");
    step(0, 0, 1, 1, 6, 2'b00, 2'b00, 2'b10, "ovr_load6");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b10, "ovr_c2");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b10, "ovr_c3");
    step(0, 1, 1, 1, 2, 2'b00, 2'b11, 2'b10, "coin_wrap");
    step(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b10, "div6_c1");
    step(0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b10, "div6_c2");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b10, "div6_c3");
    step(0, 1, 0, 0, 0, 2'b10, 2'b01, 2'b10, "div6_c4");
    step(0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, "div6_c5");
    step(0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, "div6_wrap");
    step(0, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, "div2_c1");
    step(0, 1, 0, 0, 0, 2'b00, 2'b11, 2'b00, "div2_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_freq_div.md
PROG_FREQ_DIV -- requirements
Module: prog_freq_div

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels, 1..16.
REQ-002 Parameter DIV_W, default 16: divisor and counter width in bits, 2..32.
REQ-003 Parameter DEFAULT_DIV, default 4: divisor loaded into every channel at reset; must be at least 2.
REQ-004 clk  input  1: single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 en  input  1: global count enable.
REQ-007 load  input  1: single-cycle divisor write strobe.
REQ-008 load_ch  input  4: target channel index for load.
REQ-009 load_div  input  DIV_W: new divisor value.
REQ-010 out  output  NUM_CH: registered divided clock, one bit per channel.
REQ-011 tick  output  NUM_CH: registered one-cycle period-start pulse per channel.
REQ-012 pend  output  NUM_CH: high while a channel holds a loaded but not yet applied divisor.

Function
REQ-013 Each channel SHALL hold an active divisor D, a pending divisor P with valid flag, and counter cnt; effective divisor E = 2 when D < 2, else E = D.
REQ-014 On an edge with en=1, cnt_next SHALL be 0 when cnt == E-1, else cnt+1; with en=0, cnt, out and D SHALL hold.
REQ-015 out SHALL be registered as (cnt_next >= E>>1): low for floor(E/2) cycles, then high for ceil(E/2) cycles; the period is exactly E enabled cycles.
REQ-016 tick SHALL be high for exactly the one cycle after each wrap edge (cnt == 0 following E-1), never after reset alone, and 0 whenever en=0.
REQ-017 load=1 with load_ch < NUM_CH SHALL write load_div to P of that channel and set its pend flag on the same edge.
REQ-018 load with load_ch >= NUM_CH SHALL be ignored with no state change.
REQ-019 A second load to a channel still pending SHALL overwrite P; the last written value wins.
REQ-020 At a wrap edge with pend set, D SHALL take P and pend SHALL clear; the new E applies from cnt = 0 onward, so no shortened or lengthened period is ever produced.
REQ-021 A load coinciding with a wrap edge of the same channel SHALL apply the P held before that edge (if any) and retain the new value pending for the next wrap.
REQ-022 Loads SHALL be accepted while en=0; application waits for the next enabled wrap.
REQ-023 Channels SHALL be fully independent except for shared en and load bus.

Reset
REQ-024 rst=1 SHALL set every cnt=0, D=DEFAULT_DIV, P=0, pend=0, out=0, tick=0; it SHALL override en and load on the same edge.
REQ-025 Reset asserted mid-period or with loads pending SHALL discard pending divisors; the first post-reset period is a full DEFAULT_DIV period.

Configuration
REQ-026 Macro PROG_FREQ_DIV_TICK_EN defined: tick SHALL behave per REQ-016.
REQ-027 Macro PROG_FREQ_DIV_TICK_EN undefined: tick SHALL be constant 0 and no tick registers SHALL be synthesised; all other behaviour is unchanged.

Verification (NUM_CH=2, DIV_W=8, DEFAULT_DIV=4, PROG_FREQ_DIV_TICK_EN defined)
REQ-028 Reset 3 cycles, release with en=1 -> both out sequences 0,1,1,0,0,1,1 after release edges; tick on the cycle after every 4th enabled edge.
REQ-029 Load ch1 div 5 at cnt=1 -> pend[1]=1, current 4-period completes, then out[1] low 2 and high 3 repeating; pend[1] clears at the wrap; ch0 unaffected.
REQ-030 Load div 0, then div 1, into ch0 -> each yields period 2, out toggling every cycle.
REQ-031 en=0 for 3 cycles mid-period -> out and cnt frozen, tick=0; on resume, the period completes with exactly the remaining cycle count.
REQ-032 Load ch0 div 7, then assert rst before the wrap -> pend=0, period returns to 4.
REQ-033 load with load_ch=3 and load_div=9 -> no pend change, periods unchanged.
